// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank: access FSM encoding,
// error-cause bit positions and the byte-lane mask expander.
package apb_regbank_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } apb_state_e;

    // Bit positions within the latched error-cause vector
    localparam int unsigned ErrW      = 3;
    localparam int unsigned ERR_RANGE = 0;
    localparam int unsigned ERR_RO    = 1;
    localparam int unsigned ERR_PRIV  = 2;

    localparam int unsigned MaxRW    = 32;
    localparam int unsigned MaxLanes = MaxRW / 8;

    function automatic logic [MaxRW-1:0] lane_mask(input logic [MaxLanes-1:0] strb);
        logic [MaxRW-1:0] m;
        m = '0;
        for (int b = 0; b < int'(MaxLanes); b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_regbank_fsm.sv
// APB access FSM: latches the setup phase, counts wait states and decides
// pready, pslverr and when a write may be committed.
module apb_regbank_fsm
    import apb_regbank_pkg::*;
#(
    parameter int unsigned RW   = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned NREG = 24,
    parameter int unsigned NRO  = 4,
    parameter int unsigned WAIT = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            psel_i,
    input  logic            penable_i,
    input  logic            pwrite_i,
    input  logic [RAW-1:0]  paddr_i,
    input  logic [RW-1:0]   pwdata_i,
    input  logic [RW/8-1:0] pstrb_i,
    input  logic [2:0]      pprot_i,
    output logic            setup_o,
    output logic            wait_tick_o,
    output logic            commit_o,
    output logic            pready_o,
    output logic            pslverr_o,
    output logic [RAW-1:0]  addr_o,
    output logic            write_o,
    output logic [RW-1:0]   wdata_o,
    output logic [RW/8-1:0] strb_o
);

    localparam logic [RAW:0] NregW   = (RAW+1)'(NREG);
    localparam logic [RAW:0] RoBaseW = (RAW+1)'(NREG - NRO);
    localparam logic [3:0]   WaitW   = 4'(WAIT);

    apb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [RAW-1:0]    addr_q;
    logic              write_q;
    logic [RW-1:0]     wdata_q;
    logic [RW/8-1:0]   strb_q;
    logic [ErrW-1:0]   err_q, err_cause;
    logic [RAW:0]      idx_ext;
    logic              unused_prot;

    assign unused_prot = ^pprot_i[2:1];

    // Error classification happens on the setup-phase inputs and is frozen
    always_comb begin
        idx_ext = {1'b0, paddr_i};
        err_cause = '0;
        err_cause[ERR_RANGE] = (idx_ext >= NregW);
        err_cause[ERR_RO]    = pwrite_i && (idx_ext >= RoBaseW) && (idx_ext < NregW);
        err_cause[ERR_PRIV]  = pwrite_i && !pprot_i[0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        setup_o     = 1'b0;
        wait_tick_o = 1'b0;
        commit_o    = 1'b0;
        pready_o    = 1'b0;
        case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    setup_o = 1'b1;
                    cnt_d   = WaitW;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                pready_o = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d       = cnt_q - 4'd1;
                    wait_tick_o = 1'b1;
                end
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (penable_i && pready_o) begin
                    state_d  = StIdle;
                    commit_o = write_q && (err_q == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pslverr_o = pready_o && (err_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup_o) begin
                addr_q  <= paddr_i;
                write_q <= pwrite_i;
                wdata_q <= pwdata_i;
                strb_q  <= pstrb_i;
                err_q   <= err_cause;
            end
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign wdata_o = wdata_q;
    assign strb_o  = strb_q;

endmodule

// File: rtl/apb_regbank.sv
// APB register bank top: RW control storage with byte-strobe merge, RO status
// readback, registered read data and per-register write pulses.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int unsigned RW   = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned NREG = 24,
    parameter int unsigned NRO  = 4,
    parameter int unsigned WAIT = 0
) (
    input  logic                                    apb_pclk,
    input  logic                                    nreset,
    input  logic [RAW-1:0]                          apb_paddr,
    input  logic                                    apb_psel,
    input  logic                                    apb_penable,
    input  logic                                    apb_pwrite,
    input  logic [RW-1:0]                           apb_pwdata,
    input  logic [RW/8-1:0]                         apb_pstrb,
    input  logic [2:0]                              apb_pprot,
    output logic                                    apb_pready,
    output logic [RW-1:0]                           apb_prdata,
    output logic                                    apb_pslverr,
    output logic [RW*(NREG-NRO)-1:0]                ctrl,
    output logic [NREG-NRO-1:0]                     wr_pulse,
    input  logic [RW*(NRO > 0 ? NRO : 1)-1:0]       status
);

    localparam int unsigned NRW = NREG - NRO;

    logic              setup, wait_tick, commit, write_q;
    logic [RAW-1:0]    addr_q;
    logic [RW-1:0]     wdata_q;
    logic [RW/8-1:0]   strb_q;

    logic [RW-1:0]     regs_q [NRW];
    logic [RW-1:0]     regs_d [NRW];
    logic [NRW-1:0]    wr_pulse_q, wr_pulse_d;
    logic [RW-1:0]     prdata_q, prdata_d;
    logic [MaxRW-1:0]  mask_full;
    logic [RW-1:0]     mask;
    logic [RAW-1:0]    rd_addr;
    logic              rd_write;
    logic [RW-1:0]     rd_val;
    logic              unused_mask;

    apb_regbank_fsm #(
        .RW   (RW),
        .RAW  (RAW),
        .NREG (NREG),
        .NRO  (NRO),
        .WAIT (WAIT)
    ) u_fsm (
        .clk_i       (apb_pclk),
        .rst_ni      (nreset),
        .psel_i      (apb_psel),
        .penable_i   (apb_penable),
        .pwrite_i    (apb_pwrite),
        .paddr_i     (apb_paddr),
        .pwdata_i    (apb_pwdata),
        .pstrb_i     (apb_pstrb),
        .pprot_i     (apb_pprot),
        .setup_o     (setup),
        .wait_tick_o (wait_tick),
        .commit_o    (commit),
        .pready_o    (apb_pready),
        .pslverr_o   (apb_pslverr),
        .addr_o      (addr_q),
        .write_o     (write_q),
        .wdata_o     (wdata_q),
        .strb_o      (strb_q)
    );

    assign mask_full   = lane_mask(MaxLanes'(strb_q));
    assign mask        = mask_full[RW-1:0];
    assign unused_mask = ^mask_full;

    // commit is only raised for error-free writes, so addr_q is a valid RW index
    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < int'(NRW); i++) begin
            regs_d[i] = regs_q[i];
            if (commit && (addr_q == RAW'(i))) begin
                regs_d[i]     = (regs_q[i] & ~mask) | (wdata_q & mask);
                wr_pulse_d[i] = 1'b1;
            end
        end
    end

    // On the setup edge the latch is not yet loaded, so decode the live bus
    always_comb begin
        rd_addr  = setup ? apb_paddr : addr_q;
        rd_write = setup ? apb_pwrite : write_q;
        rd_val   = '0;
        if (!rd_write) begin
            for (int i = 0; i < int'(NRW); i++) begin
                if (rd_addr == RAW'(i)) rd_val = regs_q[i];
            end
            for (int j = 0; j < int'(NRO); j++) begin
                if (rd_addr == RAW'(NRW + j)) rd_val = status[j*RW +: RW];
            end
        end
        prdata_d = (setup || wait_tick) ? rd_val : prdata_q;
    end

    always_ff @(posedge apb_pclk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(NRW); i++) regs_q[i] <= '0;
            wr_pulse_q <= '0;
            prdata_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NRW); i++) regs_q[i] <= regs_d[i];
            wr_pulse_q <= wr_pulse_d;
            prdata_q   <= prdata_d;
        end
    end

    for (genvar i = 0; i < int'(NRW); i++) begin : g_ctrl
        assign ctrl[i*RW +: RW] = regs_q[i];
    end

    assign wr_pulse   = wr_pulse_q;
    assign apb_prdata = prdata_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: three instances (WAIT=0, 3, 2) share one bus,
// each selected by its own psel.
module tb_apb_regbank;

    logic          clk, nreset;
    logic [4:0]    paddr;
    logic [2:0]    psel;
    logic          penable, pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [2:0]    pready, pslverr;
    logic [31:0]   prdata [3];
    logic [639:0]  ctrl0, ctrl3, ctrl2;
    logic [19:0]   wp0, wp3, wp2;
    logic [127:0]  status;

    int tests = 0;
    int fails = 0;
    logic [31:0] rd;
    logic        er;
    int          nw;

    localparam logic [31:0] S0 = 32'h1111_0000;
    localparam logic [31:0] S1 = 32'h2222_0001;
    localparam logic [31:0] S2 = 32'h3333_0002;
    localparam logic [31:0] S3 = 32'h4444_0003;

    assign status = {S3, S2, S1, S0};

    apb_regbank u0 (
        .apb_pclk(clk), .nreset(nreset), .apb_paddr(paddr), .apb_psel(psel[0]),
        .apb_penable(penable), .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
        .apb_pprot(pprot), .apb_pready(pready[0]), .apb_prdata(prdata[0]),
        .apb_pslverr(pslverr[0]), .ctrl(ctrl0), .wr_pulse(wp0), .status(status)
    );

    apb_regbank #(.WAIT(3)) u3 (
        .apb_pclk(clk), .nreset(nreset), .apb_paddr(paddr), .apb_psel(psel[1]),
        .apb_penable(penable), .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
        .apb_pprot(pprot), .apb_pready(pready[1]), .apb_prdata(prdata[1]),
        .apb_pslverr(pslverr[1]), .ctrl(ctrl3), .wr_pulse(wp3), .status(status)
    );

    apb_regbank #(.WAIT(2)) u2 (
        .apb_pclk(clk), .nreset(nreset), .apb_paddr(paddr), .apb_psel(psel[2]),
        .apb_penable(penable), .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
        .apb_pprot(pprot), .apb_pready(pready[2]), .apb_prdata(prdata[2]),
        .apb_pslverr(pslverr[2]), .ctrl(ctrl2), .wr_pulse(wp2), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns one cycle after the completing edge (i.e. in cycle T+2 for WAIT=0)
    task automatic xfer(input int k, input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rdo, output logic ero, output int nwo);
        psel    = 3'b000;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        pprot   = p;
        @(posedge clk); #1;
        penable = 1'b1;
        nwo = 0;
        while (!pready[k] && nwo < 40) begin
            @(posedge clk); #1;
            nwo++;
        end
        rdo = prdata[k];
        ero = pslverr[k];
        @(posedge clk); #1;
    endtask

    task automatic idle();
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        nreset = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 128'(pready), 128'(3'b000));
        check("rst_pslverr", 128'(pslverr), 128'(3'b000));
        check("rst_prdata", 128'(prdata[0]), 128'(0));
        check("rst_wr_pulse", 128'(wp0), 128'(0));
        check("rst_ctrl", 128'(ctrl0[127:0]), 128'(0));
        nreset = 1'b1;
        @(posedge clk); #1;

        // Read every index after reset
        for (int i = 0; i < 24; i++) begin
            xfer(0, 1'b0, 5'(i), 32'h0, 4'h0, 3'b001, rd, er, nw);
            case (i)
                20: check($sformatf("rd_idx%0d", i), 128'(rd), 128'(S0));
                21: check($sformatf("rd_idx%0d", i), 128'(rd), 128'(S1));
                22: check($sformatf("rd_idx%0d", i), 128'(rd), 128'(S2));
                23: check($sformatf("rd_idx%0d", i), 128'(rd), 128'(S3));
                default: check($sformatf("rd_idx%0d", i), 128'(rd), 128'(0));
            endcase
            check($sformatf("rd_err%0d", i), 128'(er), 128'(0));
        end
        idle();
        check("ctrl_zero", ctrl0[639:512], 128'(0));

        // Full write then partial-strobe merge on reg 3
        xfer(0, 1'b1, 5'd3, 32'h1234_5678, 4'hF, 3'b001, rd, er, nw);
        check("w3_full_ctrl", 128'(ctrl0[3*32 +: 32]), 128'(32'h1234_5678));
        idle();
        xfer(0, 1'b1, 5'd3, 32'hA5A5_A5A5, 4'b0101, 3'b001, rd, er, nw);
        check("w3_strb_err", 128'(er), 128'(0));
        check("w3_strb_pulse", 128'(wp0), 128'(20'h00008));
        check("w3_strb_ctrl", 128'(ctrl0[3*32 +: 32]), 128'(32'h12A5_56A5));
        idle();
        check("w3_pulse_gone", 128'(wp0), 128'(0));
        xfer(0, 1'b0, 5'd3, 32'h0, 4'h0, 3'b000, rd, er, nw);
        check("unpriv_rd_data", 128'(rd), 128'(32'h12A5_56A5));
        check("unpriv_rd_err", 128'(er), 128'(0));
        idle();

        // Error cases
        xfer(0, 1'b1, 5'd22, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, er, nw);
        check("ro_wr_err", 128'(er), 128'(1));
        check("ro_wr_pulse", 128'(wp0), 128'(0));
        idle();
        xfer(0, 1'b0, 5'd22, 32'h0, 4'h0, 3'b001, rd, er, nw);
        check("ro_rd_data", 128'(rd), 128'(S2));
        idle();
        xfer(0, 1'b0, 5'd30, 32'h0, 4'h0, 3'b001, rd, er, nw);
        check("range_rd_data", 128'(rd), 128'(0));
        check("range_rd_err", 128'(er), 128'(1));
        idle();
        xfer(0, 1'b1, 5'd1, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, er, nw);
        check("priv_wr_err", 128'(er), 128'(1));
        check("priv_wr_pulse", 128'(wp0), 128'(0));
        check("priv_wr_ctrl", 128'(ctrl0[1*32 +: 32]), 128'(0));
        idle();

        // WAIT=3 instance
        xfer(1, 1'b1, 5'd0, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, er, nw);
        check("w3wait_waits", 128'(nw), 128'(3));
        check("w3wait_err", 128'(er), 128'(0));
        check("w3wait_pready_after", 128'(pready[1]), 128'(0));
        check("w3wait_pulse", 128'(wp3), 128'(20'h00001));
        idle();
        xfer(1, 1'b0, 5'd0, 32'h0, 4'h0, 3'b001, rd, er, nw);
        check("r3wait_waits", 128'(nw), 128'(3));
        check("r3wait_data", 128'(rd), 128'(32'hDEAD_BEEF));
        idle();

        // Abort in second wait cycle on WAIT=2 instance
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 5'd0;
        pwdata = 32'h0000_0055; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        check("abort_pready", 128'(pready[2]), 128'(0));
        @(posedge clk); #1;
        check("abort_ctrl", 128'(ctrl2[31:0]), 128'(0));
        check("abort_pulse", 128'(wp2), 128'(0));
        @(posedge clk); #1;
        check("abort_pulse_late", 128'(wp2), 128'(0));
        xfer(2, 1'b1, 5'd0, 32'h0000_0077, 4'hF, 3'b001, rd, er, nw);
        check("post_abort_waits", 128'(nw), 128'(2));
        check("post_abort_pulse", 128'(wp2), 128'(20'h00001));
        check("post_abort_ctrl", 128'(ctrl2[31:0]), 128'(32'h77));
        idle();

        // Reset in the middle of an ACCESS on the WAIT=3 instance
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 5'd1;
        pwdata = 32'h0000_CAFE; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        check("midrst_pready", 128'(pready[1]), 128'(0));
        check("midrst_ctrl3", 128'(ctrl3[63:0]), 128'(0));
        check("midrst_ctrl0", ctrl0[127:0], 128'(0));
        psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 5'd1, 32'h0, 4'h0, 3'b001, rd, er, nw);
        check("midrst_rd_waits", 128'(nw), 128'(3));
        check("midrst_rd_data", 128'(rd), 128'(0));
        idle();

        // Back-to-back writes, no idle gap
        xfer(0, 1'b1, 5'd0, 32'h1111_1111, 4'hF, 3'b001, rd, er, nw);
        check("b2b0_waits", 128'(nw), 128'(0));
        check("b2b0_pulse", 128'(wp0), 128'(20'h00001));
        xfer(0, 1'b1, 5'd1, 32'h2222_2222, 4'hF, 3'b001, rd, er, nw);
        check("b2b1_waits", 128'(nw), 128'(0));
        check("b2b1_pulse", 128'(wp0), 128'(20'h00002));
        xfer(0, 1'b1, 5'd2, 32'h3333_3333, 4'hF, 3'b001, rd, er, nw);
        check("b2b2_waits", 128'(nw), 128'(0));
        check("b2b2_pulse", 128'(wp0), 128'(20'h00004));
        idle();
        check("b2b_ctrl", 128'(ctrl0[95:0]), 128'({32'h3333_3333, 32'h2222_2222, 32'h1111_1111}));
        check("b2b_pulse_gone", 128'(wp0), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
